jtag_dtm_sync: RTL and testbench
================================

// Module: jtag_dtm_sync
// PURPOSE
//  Target-side JTAG Debug Transport Module: responds to a host driving TCK/TMS/TDI (the sim bench or a probe).
//  Oversamples the JTAG pins in the core clk domain, runs the IEEE 1149.1 TAP FSM, holds IR/IDCODE/DTMCS/DMI/BYPASS,
//  and turns DMI Update-DR into a valid/ready request toward the debug module; response is captured on next Capture-DR.
//  Sits in tinyriscv_soc_top between the jtag_* pins and the DM, replacing the TCK-clocked driver with a single-clock design.
// PARAMETERS
//  IDCODE      32'h1e200a6d  value loaded into DR on Capture-DR when IR=0x01
//  DMI_ABITS   6             DMI address width; DMI DR width = DMI_ABITS+34 (40 at default)
//  DTM_IDLE    5             DTMCS.idle hint field (3 bits used)
//  SYNC_STAGES 2             synchronizer flops on TCK/TMS/TDI (>=2)
// PORTS
//  clk            in   1               core clock; all logic on posedge
//  rst            in   1               synchronous, active-high reset
//  jtag_TCK       in   1               async JTAG clock (sampled, never used as a clock)
//  jtag_TMS       in   1               async test mode select
//  jtag_TDI       in   1               async test data in
//  jtag_TDO       out  1               test data out, updated on synchronized TCK falling edge
//  dtm_req_valid  out  1               DMI request pending
//  dtm_req_ready  in   1               DM accepts request when valid&ready on clk edge
//  dtm_req_data   out  DMI_ABITS+34    {addr, data[31:0], op[1:0]}, stable while valid
//  dtm_resp_valid in   1               1-cycle pulse: DM response available
//  dtm_resp_data  in   32              DM read data, sampled when dtm_resp_valid
// BEHAVIOUR
//  Reset: TAP=TEST_LOGIC_RESET, IR=5'h01, jtag_TDO=0, dtm_req_valid=0, dtm_req_data=0, sticky_busy=0, resp reg=0.
//  Sampling: TCK/TMS/TDI pass SYNC_STAGES flops + 1 history flop; tck_rise/tck_fall = 1-clk pulses. TMS/TDI values
//   used are the synchronized ones in the same cycle as tck_rise. Pin-to-action latency = SYNC_STAGES+1 clk.
//   Host must hold TCK high and low >= SYNC_STAGES+2 clk each; faster TCK is unsupported (no detection).
//  TAP FSM (advances only on tck_rise, per TMS): TLR,RTI,SEL_DR,CAP_DR,SH_DR,EX1_DR,PA_DR,EX2_DR,UPD_DR,
//   SEL_IR,CAP_IR,SH_IR,EX1_IR,PA_IR,EX2_IR,UPD_IR -- standard 1149.1 arcs; 5 rising edges with TMS=1 reach TLR.
//  Actions on tck_rise, keyed on state BEFORE transition:
//   TLR: IR<=5'h01. CAP_IR: ir_sh<=5'b00001. SH_IR: ir_sh<={TDI,ir_sh[4:1]}. UPD_IR: IR<=ir_sh.
//   CAP_DR: load dr_sh by IR: 01 IDCODE; 10 DTMCS={14'b0,2'b0,1'b0,DTM_IDLE[2:0],dmistat,DMI_ABITS[5:0],4'h1};
//     11 DMI={last_addr,resp_data,dmistat}; else (incl. 1f) BYPASS 1'b0.
//   SH_DR: dr_sh<={TDI,dr_sh[W-1:1]} over active length (32/32/DMI_ABITS+34/1). LSB-first, TDI enters MSB.
//   UPD_DR IR=10: bit16 (dmireset) clears sticky_busy; bit17 (dmihardreset) clears sticky_busy AND drops req_valid.
//   UPD_DR IR=11: op=dr_sh[1:0]; op 1/2 & no request outstanding -> dtm_req_valid<=1, dtm_req_data<=dr_sh,
//     last_addr<=addr; op 1/2 while outstanding -> sticky_busy<=1, request ignored; op 0/3 -> no action.
//  jtag_TDO: on tck_fall, TDO<=ir_sh[0] in SH_IR, dr_sh[0] in SH_DR, else holds value.
//  dmistat = 2'b11 if sticky_busy or req outstanding or awaiting response, else 2'b00.
//  Handshake: req_valid drops the cycle after valid&ready; outstanding stays set until dtm_resp_valid, which loads
//   resp_data. resp_valid w/o outstanding request: data still latched. resp_valid and UPD_DR same clk: response
//   completes first, new request issued (no busy).
//  rst mid-operation: all state to reset values on next clk regardless of TCK phase; a pending request is dropped.
// TESTING
//  T1: 8 TCK cycles TMS=1 -> TAP=TLR, IR=01; then IDLE, Capture/Shift-DR 32 bits -> TDO stream = 32'h1e200a6d LSB-first.
//  T2: Shift-IR 5'b10001 (DMI) -> TDO shifts out 5'b00001; after Update-IR IR=5'h11; DTMCS read -> abits=6, version=1.
//  T3: DMI write {6'h10,32'h0,2'b10} + Update-DR -> dtm_req_valid=1, data=40'h40_0000_0002; ready held 3 clk later
//   -> valid low next clk; resp pulse -> dmistat 00.
//  T4: DMI read op=1 addr 0x11, DM returns 32'h0040_0382 -> next DMI scan (op=0) TDO bits[33:2]=32'h00400382, [1:0]=00.
//  T5: issue second DMI op while ready held 0 -> sticky_busy, scan shows status 2'b11; DTMCS write bit16 -> status 00.
//  T6: assert rst with request pending and TAP in SH_DR -> next clk req_valid=0, TDO=0, IR=01, TAP=TLR.

Source files
------------

// File: rtl/jtag_dtm_sync.sv
// JTAG Debug Transport Module running entirely in the core clock domain.
// TCK/TMS/TDI are oversampled; TAP, IR/DR shifters and the DMI request/response handshake live on clk.
module jtag_dtm_sync #(
  parameter logic [31:0] IDCODE      = 32'h1e200a6d,
  parameter int          DMI_ABITS   = 6,
  parameter int          DTM_IDLE    = 5,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   jtag_TCK,
  input  logic                   jtag_TMS,
  input  logic                   jtag_TDI,
  output logic                   jtag_TDO,
  output logic                   dtm_req_valid,
  input  logic                   dtm_req_ready,
  output logic [DMI_ABITS+33:0]  dtm_req_data,
  input  logic                   dtm_resp_valid,
  input  logic [31:0]            dtm_resp_data
);
  localparam int DW = DMI_ABITS + 34;
  localparam logic [2:0] IDLE3  = 3'(DTM_IDLE);
  localparam logic [5:0] ABITS6 = 6'(DMI_ABITS);

  localparam logic [3:0] TLR = 4'd0,  RTI = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
                         SH_DR = 4'd4, EX1_DR = 4'd5, PA_DR = 4'd6, EX2_DR = 4'd7,
                         UPD_DR = 4'd8, SEL_IR = 4'd9, CAP_IR = 4'd10, SH_IR = 4'd11,
                         EX1_IR = 4'd12, PA_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15;

  logic [SYNC_STAGES-1:0] tck_sync_q, tck_sync_d, tms_sync_q, tms_sync_d, tdi_sync_q, tdi_sync_d;
  logic                   tck_hist_q, tck_hist_d;
  logic [3:0]             tap_q, tap_d, tap_next;
  logic [4:0]             ir_q, ir_d, ir_sh_q, ir_sh_d;
  logic [DW-1:0]          dr_sh_q, dr_sh_d, req_data_q, req_data_d;
  logic [31:0]            resp_q, resp_d;
  logic [DMI_ABITS-1:0]   last_addr_q, last_addr_d;
  logic                   tdo_q, tdo_d, req_valid_q, req_valid_d;
  logic                   outstanding_q, outstanding_d, sticky_q, sticky_d;
  logic                   tck_s, tms_s, tdi_s, tck_rise, tck_fall;
  logic [1:0]             dmistat;

  assign tck_s    = tck_sync_q[SYNC_STAGES-1];
  assign tms_s    = tms_sync_q[SYNC_STAGES-1];
  assign tdi_s    = tdi_sync_q[SYNC_STAGES-1];
  assign tck_rise = tck_s & ~tck_hist_q;
  assign tck_fall = ~tck_s & tck_hist_q;
  assign dmistat  = (sticky_q | outstanding_q) ? 2'b11 : 2'b00;

  assign jtag_TDO      = tdo_q;
  assign dtm_req_valid = req_valid_q;
  assign dtm_req_data  = req_data_q;

  always_comb begin
    tap_next = tap_q;
    case (tap_q)
      TLR:    tap_next = tms_s ? TLR    : RTI;
      RTI:    tap_next = tms_s ? SEL_DR : RTI;
      SEL_DR: tap_next = tms_s ? SEL_IR : CAP_DR;
      CAP_DR: tap_next = tms_s ? EX1_DR : SH_DR;
      SH_DR:  tap_next = tms_s ? EX1_DR : SH_DR;
      EX1_DR: tap_next = tms_s ? UPD_DR : PA_DR;
      PA_DR:  tap_next = tms_s ? EX2_DR : PA_DR;
      EX2_DR: tap_next = tms_s ? UPD_DR : SH_DR;
      UPD_DR: tap_next = tms_s ? SEL_DR : RTI;
      SEL_IR: tap_next = tms_s ? TLR    : CAP_IR;
      CAP_IR: tap_next = tms_s ? EX1_IR : SH_IR;
      SH_IR:  tap_next = tms_s ? EX1_IR : SH_IR;
      EX1_IR: tap_next = tms_s ? UPD_IR : PA_IR;
      PA_IR:  tap_next = tms_s ? EX2_IR : PA_IR;
      EX2_IR: tap_next = tms_s ? UPD_IR : SH_IR;
      UPD_IR: tap_next = tms_s ? SEL_DR : RTI;
      default: tap_next = TLR;
    endcase
  end

  always_comb begin
    tck_sync_d    = {tck_sync_q[SYNC_STAGES-2:0], jtag_TCK};
    tms_sync_d    = {tms_sync_q[SYNC_STAGES-2:0], jtag_TMS};
    tdi_sync_d    = {tdi_sync_q[SYNC_STAGES-2:0], jtag_TDI};
    tck_hist_d    = tck_s;
    tap_d         = tap_q;
    ir_d          = ir_q;
    ir_sh_d       = ir_sh_q;
    dr_sh_d       = dr_sh_q;
    tdo_d         = tdo_q;
    req_valid_d   = req_valid_q;
    req_data_d    = req_data_q;
    resp_d        = resp_q;
    last_addr_d   = last_addr_q;
    outstanding_d = outstanding_q;
    sticky_d      = sticky_q;

    // Response retires before any same-cycle Update-DR so a back-to-back op is not flagged busy.
    if (dtm_resp_valid) begin
      resp_d        = dtm_resp_data;
      outstanding_d = 1'b0;
    end
    if (req_valid_q && dtm_req_ready) req_valid_d = 1'b0;

    if (tck_rise) begin
      tap_d = tap_next;
      case (tap_q)
        TLR:    ir_d    = 5'h01;
        CAP_IR: ir_sh_d = 5'b00001;
        SH_IR:  ir_sh_d = {tdi_s, ir_sh_q[4:1]};
        UPD_IR: ir_d    = ir_sh_q;
        CAP_DR: begin
          case (ir_q)
            5'h01:   dr_sh_d = {{(DW-32){1'b0}}, IDCODE};
            5'h10:   dr_sh_d = {{(DW-32){1'b0}}, 14'b0, 2'b0, 1'b0, IDLE3, dmistat, ABITS6, 4'h1};
            5'h11:   dr_sh_d = {last_addr_q, resp_q, dmistat};
            default: dr_sh_d = '0;
          endcase
        end
        SH_DR: begin
          case (ir_q)
            5'h01, 5'h10: dr_sh_d = {{(DW-32){1'b0}}, tdi_s, dr_sh_q[31:1]};
            5'h11:        dr_sh_d = {tdi_s, dr_sh_q[DW-1:1]};
            default:      dr_sh_d = {{(DW-1){1'b0}}, tdi_s};
          endcase
        end
        UPD_DR: begin
          if (ir_q == 5'h10) begin
            if (dr_sh_q[17]) begin
              sticky_d      = 1'b0;
              req_valid_d   = 1'b0;
              outstanding_d = 1'b0;
            end else if (dr_sh_q[16]) begin
              sticky_d = 1'b0;
            end
          end else if (ir_q == 5'h11 && (dr_sh_q[1:0] == 2'd1 || dr_sh_q[1:0] == 2'd2)) begin
            if (outstanding_q && !dtm_resp_valid) begin
              sticky_d = 1'b1;
            end else begin
              req_valid_d   = 1'b1;
              req_data_d    = dr_sh_q;
              last_addr_d   = dr_sh_q[DW-1:34];
              outstanding_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end

    if (tck_fall) begin
      if (tap_q == SH_IR)      tdo_d = ir_sh_q[0];
      else if (tap_q == SH_DR) tdo_d = dr_sh_q[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tck_sync_q    <= '0;
      tms_sync_q    <= '0;
      tdi_sync_q    <= '0;
      tck_hist_q    <= 1'b0;
      tap_q         <= TLR;
      ir_q          <= 5'h01;
      ir_sh_q       <= '0;
      dr_sh_q       <= '0;
      tdo_q         <= 1'b0;
      req_valid_q   <= 1'b0;
      req_data_q    <= '0;
      resp_q        <= '0;
      last_addr_q   <= '0;
      outstanding_q <= 1'b0;
      sticky_q      <= 1'b0;
    end else begin
      tck_sync_q    <= tck_sync_d;
      tms_sync_q    <= tms_sync_d;
      tdi_sync_q    <= tdi_sync_d;
      tck_hist_q    <= tck_hist_d;
      tap_q         <= tap_d;
      ir_q          <= ir_d;
      ir_sh_q       <= ir_sh_d;
      dr_sh_q       <= dr_sh_d;
      tdo_q         <= tdo_d;
      req_valid_q   <= req_valid_d;
      req_data_q    <= req_data_d;
      resp_q        <= resp_d;
      last_addr_q   <= last_addr_d;
      outstanding_q <= outstanding_d;
      sticky_q      <= sticky_d;
    end
  end
endmodule

// File: tb/tb_jtag_dtm_sync.sv
// Bench for jtag_dtm_sync: bit-banged JTAG host, TDO and DMI request scoreboards.
module tb_jtag_dtm_sync;
  logic        clk = 1'b0, rst = 1'b1;
  logic        jtag_TCK = 1'b0, jtag_TMS = 1'b1, jtag_TDI = 1'b0;
  logic        jtag_TDO;
  logic        dtm_req_valid, dtm_req_ready = 1'b0;
  logic [39:0] dtm_req_data;
  logic        dtm_resp_valid = 1'b0;
  logic [31:0] dtm_resp_data = '0;

  int n_chk = 0, n_fail = 0;
  logic        exp_tdo[$];
  logic [39:0] exp_req[$];
  logic        prev_valid = 1'b0;
  logic        tdo_s;

  localparam logic [31:0] IDCODE_V = 32'h1e200a6d;
  localparam logic [31:0] DTMCS_OK = 32'h0000_5061;
  localparam logic [31:0] DTMCS_BZ = 32'h0000_5c61;

  jtag_dtm_sync dut (
    .clk(clk), .rst(rst),
    .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI), .jtag_TDO(jtag_TDO),
    .dtm_req_valid(dtm_req_valid), .dtm_req_ready(dtm_req_ready), .dtm_req_data(dtm_req_data),
    .dtm_resp_valid(dtm_resp_valid), .dtm_resp_data(dtm_resp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // New requests are matched against the queue when valid rises.
  always @(negedge clk) begin
    if (dtm_req_valid && !prev_valid) begin
      if (exp_req.size() == 0) chk("req_unexpected", 64'd1, 64'd0);
      else chk("req_data", 64'(dtm_req_data), 64'(exp_req.pop_front()));
    end
    prev_valid = dtm_req_valid;
  end

  // One TCK period: TMS/TDI set for the low half, TDO sampled just before the rise.
  task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo);
    jtag_TMS = tms;
    jtag_TDI = tdi;
    repeat (8) @(negedge clk);
    tdo = jtag_TDO;
    jtag_TCK = 1'b1;
    repeat (8) @(negedge clk);
    jtag_TCK = 1'b0;
  endtask

  task automatic shift_n(input int len, input logic [63:0] din, input string tag);
    logic t;
    for (int i = 0; i < len; i++) begin
      tck_cycle(i == len - 1, din[i], t);
      if (exp_tdo.size() == 0) chk({tag, "_underflow"}, 64'd1, 64'd0);
      else chk(tag, 64'(t), 64'(exp_tdo.pop_front()));
    end
  endtask

  task automatic scan_ir(input logic [4:0] ir);
    logic [63:0] v;
    v = 64'(ir);
    for (int i = 0; i < 5; i++) exp_tdo.push_back(i == 0);
    tck_cycle(1, 0, tdo_s); tck_cycle(1, 0, tdo_s);
    tck_cycle(0, 0, tdo_s); tck_cycle(0, 0, tdo_s);
    shift_n(5, v, "ir_tdo");
    tck_cycle(1, 0, tdo_s); tck_cycle(0, 0, tdo_s);
  endtask

  task automatic scan_dr(input int len, input logic [63:0] din, input logic [63:0] dexp, input string tag);
    for (int i = 0; i < len; i++) exp_tdo.push_back(dexp[i]);
    tck_cycle(1, 0, tdo_s); tck_cycle(0, 0, tdo_s); tck_cycle(0, 0, tdo_s);
    shift_n(len, din, tag);
    tck_cycle(1, 0, tdo_s); tck_cycle(0, 0, tdo_s);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 40 && !dtm_req_valid; i++) @(negedge clk);
    chk(tag, 64'(dtm_req_valid), 64'd1);
  endtask

  task automatic ready_pulse();
    dtm_req_ready = 1'b1;
    @(negedge clk);
    dtm_req_ready = 1'b0;
  endtask

  task automatic resp_pulse(input logic [31:0] d);
    dtm_resp_valid = 1'b1;
    dtm_resp_data  = d;
    @(negedge clk);
    dtm_resp_valid = 1'b0;
  endtask

  initial begin
    repeat (4) @(negedge clk);
    chk("rst_tdo", 64'(jtag_TDO), 64'd0);
    chk("rst_valid", 64'(dtm_req_valid), 64'd0);
    chk("rst_data", 64'(dtm_req_data), 64'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // T1: TAP reset then IDCODE readout
    for (int i = 0; i < 8; i++) tck_cycle(1, 0, tdo_s);
    tck_cycle(0, 0, tdo_s);
    scan_dr(32, 64'd0, 64'(IDCODE_V), "idcode");

    // T2: DTMCS then select DMI
    scan_ir(5'h10);
    scan_dr(32, 64'd0, 64'(DTMCS_OK), "dtmcs");
    scan_ir(5'h11);

    // T3: DMI write
    exp_req.push_back(40'h40_0000_0002);
    scan_dr(40, 64'h40_0000_0002, 64'd0, "dmi_w");
    wait_valid("t3_valid");
    repeat (3) @(negedge clk);
    chk("t3_hold", 64'(dtm_req_data), 64'h40_0000_0002);
    ready_pulse();
    chk("t3_drop", 64'(dtm_req_valid), 64'd0);
    resp_pulse(32'h1234_5678);

    // T4: DMI read of 0x11
    exp_req.push_back({6'h11, 32'h0, 2'b01});
    scan_dr(40, {24'd0, 6'h11, 32'h0, 2'b01}, {24'd0, 6'h10, 32'h1234_5678, 2'b00}, "dmi_r");
    wait_valid("t4_valid");
    ready_pulse();
    resp_pulse(32'h0040_0382);
    scan_dr(40, {24'd0, 6'h11, 32'h0, 2'b00}, {24'd0, 6'h11, 32'h0040_0382, 2'b00}, "dmi_rd");

    // T5: busy then dmireset
    exp_req.push_back({6'h05, 32'ha5a5_a5a5, 2'b10});
    scan_dr(40, {24'd0, 6'h05, 32'ha5a5_a5a5, 2'b10}, {24'd0, 6'h11, 32'h0040_0382, 2'b00}, "dmi_w2");
    wait_valid("t5_valid");
    scan_dr(40, {24'd0, 6'h06, 32'h0, 2'b10}, {24'd0, 6'h05, 32'h0040_0382, 2'b11}, "dmi_busy");
    chk("t5_kept", 64'(dtm_req_data), {24'd0, 6'h05, 32'ha5a5_a5a5, 2'b10});
    ready_pulse();
    chk("t5_drop", 64'(dtm_req_valid), 64'd0);
    resp_pulse(32'hcafe_0001);
    scan_dr(40, 64'd0, {24'd0, 6'h05, 32'hcafe_0001, 2'b11}, "dmi_sticky");
    scan_ir(5'h10);
    scan_dr(32, 64'h0001_0000, 64'(DTMCS_BZ), "dtmcs_bz");
    scan_dr(32, 64'd0, 64'(DTMCS_OK), "dtmcs_clr");

    // T6: reset with request pending, TAP in Shift-DR
    scan_ir(5'h11);
    exp_req.push_back({6'h07, 32'h0, 2'b01});
    scan_dr(40, {24'd0, 6'h07, 32'h0, 2'b01}, {24'd0, 6'h05, 32'hcafe_0001, 2'b00}, "dmi_r2");
    wait_valid("t6_valid");
    tck_cycle(1, 0, tdo_s); tck_cycle(0, 0, tdo_s); tck_cycle(0, 0, tdo_s);
    tck_cycle(0, 1, tdo_s);
    chk("t6_tdo_pre", 64'(tdo_s), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_valid", 64'(dtm_req_valid), 64'd0);
    chk("t6_tdo", 64'(jtag_TDO), 64'd0);
    chk("t6_data", 64'(dtm_req_data), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tck_cycle(0, 0, tdo_s);
    scan_dr(32, 64'd0, 64'(IDCODE_V), "idcode_rst");
    scan_ir(5'h10);
    scan_dr(32, 64'd0, 64'(DTMCS_OK), "dtmcs_rst");

    repeat (4) @(negedge clk);
    chk("tdo_q_empty", 64'(exp_tdo.size()), 64'd0);
    chk("req_q_empty", 64'(exp_req.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
